// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, divide and memory waits, and
// taken-branch wrong-path kill, with a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rj_no_id,
    input  logic [4:0]       rk_no_id,
    input  logic [4:0]       rd_no_id,
    input  logic             rj_use_id,
    input  logic             rk_use_id,
    input  logic             rd_use_id,
    input  logic [4:0]       rd_no_ex,
    input  logic             regWriteEn_ex,
    input  logic             memRead_ex,
    input  logic             div_start_ex,
    input  logic             div_done,
    input  logic             dreq_mem,
    input  logic             data_ok_mem,
    input  logic             branch_taken_ex,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             bubble_ex,
    output logic             bubble_mem,
    output logic             bubble_wb,
    output logic             flush_id,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_WAIT  = 2'd1,
        DIV_WAIT = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   div_pend, div_pend_nx;
    logic   done_lat, done_lat_nx;
    logic   lu_pend, lu_pend_nx;
    logic   luh, mw, src_match;

    assign src_match = (rj_use_id && (rj_no_id == rd_no_ex)) ||
                       (rk_use_id && (rk_no_id == rd_no_ex)) ||
                       (rd_use_id && (rd_no_id == rd_no_ex));
    assign luh = memRead_ex && regWriteEn_ex && (rd_no_ex != 5'd0) && src_match;
    assign mw  = dreq_mem && !data_ok_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            div_pend <= 1'b0;
            done_lat <= 1'b0;
            lu_pend  <= 1'b0;
        end else begin
            state    <= state_nx;
            div_pend <= div_pend_nx;
            done_lat <= done_lat_nx;
            lu_pend  <= lu_pend_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        div_pend_nx = div_pend;
        done_lat_nx = done_lat;
        lu_pend_nx  = lu_pend;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_mem   = 1'b0;
        bubble_ex   = 1'b0;
        bubble_mem  = 1'b0;
        bubble_wb   = 1'b0;
        flush_id    = 1'b0;
        // Outputs stay quiet during reset; the next state is overridden by the register.
        if (!rst) begin
            if (mw) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
                bubble_wb = 1'b1;
            end
            case (state)
                RUN: begin
                    if (mw) begin
                        state_nx    = MEM_WAIT;
                        div_pend_nx = div_start_ex;
                        done_lat_nx = 1'b0;
                        lu_pend_nx  = 1'b0;
                    end else if (div_start_ex) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        bubble_mem = 1'b1;
                        state_nx   = DIV_WAIT;
                    end else if (branch_taken_ex) begin
                        flush_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (luh) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                        state_nx  = LU_WAIT;
                    end
                end
                LU_WAIT: begin
                    if (mw) begin
                        state_nx    = MEM_WAIT;
                        lu_pend_nx  = 1'b1;
                        div_pend_nx = 1'b0;
                        done_lat_nx = 1'b0;
                    end else begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                        state_nx  = RUN;
                    end
                end
                DIV_WAIT: begin
                    if (mw) begin
                        state_nx    = MEM_WAIT;
                        div_pend_nx = 1'b1;
                        done_lat_nx = div_done;
                        lu_pend_nx  = 1'b0;
                    end else if (div_done) begin
                        flush_id  = branch_taken_ex;
                        bubble_ex = branch_taken_ex;
                        state_nx  = RUN;
                    end else begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        bubble_mem = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mw) begin
                        if (div_done) done_lat_nx = 1'b1;
                    end else begin
                        // EX advances this cycle, so a held taken branch may kill now.
                        flush_id  = branch_taken_ex;
                        bubble_ex = branch_taken_ex;
                        if (lu_pend)
                            state_nx = LU_WAIT;
                        else if (div_pend && !done_lat && !div_done)
                            state_nx = DIV_WAIT;
                        else
                            state_nx = RUN;
                        div_pend_nx = 1'b0;
                        done_lat_nx = 1'b0;
                        lu_pend_nx  = 1'b0;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_if && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign state_o = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table from RUN plus
// hand-written multi-cycle sequences for waits, priorities and reset.
module tb_hazard_ctrl;

    localparam int CW = 4;
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LUH  = 8'b1100_1000;
    localparam logic [7:0] O_DIV  = 8'b1110_0100;
    localparam logic [7:0] O_MW   = 8'b1111_0010;
    localparam logic [7:0] O_BR   = 8'b0000_1001;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rj, rk, rd, rdx;
    logic          uj, uk, ud, rw, mr, ds, dd, dq, dk, br;
    logic          stall_if, stall_id, stall_ex, stall_mem;
    logic          bubble_ex, bubble_mem, bubble_wb, flush_id;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt;
    logic [7:0]    outs;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rj_no_id(rj), .rk_no_id(rk), .rd_no_id(rd),
        .rj_use_id(uj), .rk_use_id(uk), .rd_use_id(ud),
        .rd_no_ex(rdx), .regWriteEn_ex(rw), .memRead_ex(mr),
        .div_start_ex(ds), .div_done(dd),
        .dreq_mem(dq), .data_ok_mem(dk), .branch_taken_ex(br),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .bubble_wb(bubble_wb),
        .flush_id(flush_id), .state_o(state_o), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem, bubble_wb, flush_id};

    typedef struct {
        logic [4:0] rj, rk, rd;
        logic [2:0] use_jkd;
        logic [4:0] rdx;
        logic       rw, mr, ds, dd, dq, dk, br;
        logic [7:0] eo;
        logic [1:0] es;
    } vec_t;

    vec_t vec [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rj = 0; rk = 0; rd = 0; rdx = 0;
        uj = 0; uk = 0; ud = 0; rw = 0; mr = 0;
        ds = 0; dd = 0; dq = 0; dk = 0; br = 0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_luh();
        mr = 1; rw = 1; rdx = 5'd5; rj = 5'd5; uj = 1;
    endtask

    initial begin
        vec[0]  = '{5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0};
        vec[1]  = '{5'd5, 5'd0, 5'd0, 3'b100, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LUH,  2'd1};
        vec[2]  = '{5'd0, 5'd0, 5'd0, 3'b100, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0};
        vec[3]  = '{5'd5, 5'd0, 5'd0, 3'b000, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0};
        vec[4]  = '{5'd1, 5'd7, 5'd0, 3'b010, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LUH,  2'd1};
        vec[5]  = '{5'd1, 5'd2, 5'd9, 3'b001, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LUH,  2'd1};
        vec[6]  = '{5'd5, 5'd0, 5'd0, 3'b100, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0};
        vec[7]  = '{5'd5, 5'd0, 5'd0, 3'b100, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, 2'd0};
        vec[8]  = '{5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_BR,   2'd0};
        vec[9]  = '{5'd5, 5'd0, 5'd0, 3'b100, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_BR,   2'd0};
        vec[10] = '{5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_DIV,  2'd2};
        vec[11] = '{5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_MW,   2'd3};
        vec[12] = '{5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, O_NONE, 2'd0};
        vec[13] = '{5'd5, 5'd0, 5'd0, 3'b100, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, O_MW,   2'd3};
        vec[14] = '{5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_DIV,  2'd2};

        // Reset behaviour with hazard-provoking inputs present.
        clear_in();
        rst = 1'b1;
        set_luh(); dq = 1; br = 1;
        #1;
        check("outs_in_reset", outs, O_NONE);
        tick();
        check("reset_state", state_o, 2'd0);
        check("reset_cnt", stall_cnt, 0);
        rst = 1'b0;
        clear_in();

        // Table of single cycles launched from RUN.
        for (int i = 0; i < 15; i++) begin
            do_reset();
            rj = vec[i].rj; rk = vec[i].rk; rd = vec[i].rd;
            {uj, uk, ud} = vec[i].use_jkd;
            rdx = vec[i].rdx; rw = vec[i].rw; mr = vec[i].mr;
            ds = vec[i].ds; dd = vec[i].dd; dq = vec[i].dq; dk = vec[i].dk; br = vec[i].br;
            #1;
            check($sformatf("vec%0d_outs", i), outs, vec[i].eo);
            tick();
            check($sformatf("vec%0d_state", i), state_o, vec[i].es);
            clear_in();
        end

        // Load-use: two stalled cycles, RUN -> LU_WAIT -> RUN.
        do_reset();
        set_luh();
        #1; check("lu_c0_outs", outs, O_LUH);
        tick(); clear_in();
        check("lu_c1_state", state_o, 2'd1);
        #1; check("lu_c1_outs", outs, O_LUH);
        tick();
        check("lu_end_state", state_o, 2'd0);
        check("lu_cnt", stall_cnt, 2);
        #1; check("lu_end_outs", outs, O_NONE);

        // Divide: six stalled cycles, done drops stalls.
        do_reset();
        ds = 1;
        #1; check("div_c0_outs", outs, O_DIV);
        tick(); ds = 0;
        for (int k = 0; k < 5; k++) begin
            #1; check($sformatf("div_w%0d_outs", k), outs, O_DIV);
            tick();
        end
        dd = 1;
        #1; check("div_done_outs", outs, O_NONE);
        tick(); dd = 0;
        check("div_end_state", state_o, 2'd0);
        check("div_cnt", stall_cnt, 6);

        // Memory wait of three cycles with a held taken branch.
        do_reset();
        dq = 1; br = 1;
        for (int k = 0; k < 3; k++) begin
            #1; check($sformatf("mw_c%0d_outs", k), outs, O_MW);
            tick();
        end
        dk = 1;
        #1; check("mw_exit_outs", outs, O_BR);
        tick(); clear_in();
        check("mw_end_state", state_o, 2'd0);

        // Divide done arriving inside MEM_WAIT is remembered.
        do_reset();
        ds = 1; tick(); ds = 0;
        tick();
        dq = 1;
        #1; check("dm_mw_outs", outs, O_MW);
        tick();
        check("dm_state_mem", state_o, 2'd3);
        dd = 1;
        #1; check("dm_mw_done_outs", outs, O_MW);
        tick(); dd = 0;
        dk = 1;
        #1; check("dm_exit_outs", outs, O_NONE);
        tick(); clear_in();
        check("dm_latched_state", state_o, 2'd0);

        // Without done, MEM_WAIT returns to the pending divide.
        do_reset();
        ds = 1; tick(); ds = 0;
        dq = 1; tick();
        dk = 1; tick(); clear_in();
        check("dp_state_div", state_o, 2'd2);
        #1; check("dp_outs", outs, O_DIV);
        dd = 1;
        #1; check("dp_done_outs", outs, O_NONE);
        tick(); dd = 0;
        check("dp_end_state", state_o, 2'd0);

        // Memory wait during LU_WAIT keeps the load-use penalty.
        do_reset();
        set_luh(); tick(); clear_in();
        dq = 1;
        #1; check("lm_outs", outs, O_MW);
        tick();
        check("lm_state_mem", state_o, 2'd3);
        dk = 1; tick(); clear_in();
        check("lm_state_lu", state_o, 2'd1);
        #1; check("lm_lu_outs", outs, O_LUH);
        tick();
        check("lm_end_state", state_o, 2'd0);

        // Reset during DIV_WAIT abandons the wait.
        do_reset();
        ds = 1; tick(); ds = 0;
        tick(); tick();
        rst = 1;
        #1; check("rd_outs_in_reset", outs, O_NONE);
        tick(); rst = 0;
        check("rd_state", state_o, 2'd0);
        check("rd_cnt", stall_cnt, 0);
        #1; check("rd_outs_after", outs, O_NONE);

        // Counter saturates at all ones.
        do_reset();
        dq = 1;
        for (int k = 0; k < 20; k++) tick();
        check("sat_cnt", stall_cnt, 15);
        check("sat_state", state_o, 2'd3);
        clear_in();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
